// File: rtl/mix_columns_iter.sv
// ---------------------------------------------------------------------------
// mix_columns_iter
//
// Iterative AES MixColumns stage. Takes one 128-bit state from ShiftRows
// behind a valid/ready handshake, mixes it one 32-bit column per clock
// through a single shared column mixer, and presents the result behind a
// second valid/ready handshake. Final-round states (bypass=1) are passed
// through unmixed.
//
// Parameters:
//   INVERSE  0: forward MixColumns (02,03,01,01)
//            1: InvMixColumns    (0e,0b,0d,09)
//
// Ports:
//   clk       in   1    rising-edge clock
//   rst_n     in   1    asynchronous reset, active low
//   inValid   in   1    stateIn/bypass valid this cycle
//   inReady   out  1    block can accept a state this cycle
//   stateIn   in   128  state from ShiftRows (column-major, col 0 at [127:96])
//   bypass    in   1    final round: pass state through unmixed
//   outValid  out  1    stateOut holds a completed result
//   outReady  in   1    downstream accepts stateOut this cycle
//   stateOut  out  128  mixed (or bypassed) state
// ---------------------------------------------------------------------------
module mix_columns_iter #(
    parameter bit INVERSE = 1'b0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inValid,
    output logic         inReady,
    input  logic [127:0] stateIn,
    input  logic         bypass,
    output logic         outValid,
    input  logic         outReady,
    output logic [127:0] stateOut
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e       state_q, state_d;
    logic [1:0]   col_idx_q, col_idx_d;
    logic [127:0] work_q, work_d;

    logic [31:0]  col_in;
    logic [31:0]  col_mixed;

    // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] xtime(input logic [7:0] v);
        return {v[6:0], 1'b0} ^ (v[7] ? 8'h1b : 8'h00);
    endfunction

    // Select the column currently being mixed.
    always_comb begin
        col_in = work_q[127:96];
        case (col_idx_q)
            2'd0: col_in = work_q[127:96];
            2'd1: col_in = work_q[95:64];
            2'd2: col_in = work_q[63:32];
            2'd3: col_in = work_q[31:0];
            default: col_in = work_q[127:96];
        endcase
    end

    // Shared column mixer. Row 0 of the column is the most significant byte.
    logic [7:0] a_b  [4];
    logic [7:0] x2_b [4];
    logic [7:0] x4_b [4];
    logic [7:0] x8_b [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte
            assign a_b[gi]  = col_in[31-8*gi -: 8];
            assign x2_b[gi] = xtime(a_b[gi]);
            assign x4_b[gi] = xtime(x2_b[gi]);
            assign x8_b[gi] = xtime(x4_b[gi]);
        end

        // Both matrices are circulant: row r applies coefficient k to byte
        // (r+k) mod 4, with k walking along the first matrix row.
        for (gi = 0; gi < 4; gi++) begin : g_row
            localparam int R1 = (gi + 1) % 4;
            localparam int R2 = (gi + 2) % 4;
            localparam int R3 = (gi + 3) % 4;
            if (INVERSE) begin : g_inv
                // 0e = 8^4^2, 0b = 8^2^1, 0d = 8^4^1, 09 = 8^1
                assign col_mixed[31-8*gi -: 8] =
                      (x8_b[gi] ^ x4_b[gi] ^ x2_b[gi])
                    ^ (x8_b[R1] ^ x2_b[R1] ^ a_b[R1])
                    ^ (x8_b[R2] ^ x4_b[R2] ^ a_b[R2])
                    ^ (x8_b[R3] ^ a_b[R3]);
            end else begin : g_fwd
                assign col_mixed[31-8*gi -: 8] =
                      x2_b[gi]
                    ^ (x2_b[R1] ^ a_b[R1])
                    ^ a_b[R2]
                    ^ a_b[R3];
            end
        end
    endgenerate

    // Next-state / output logic.
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        work_d    = work_q;
        inReady   = 1'b0;
        outValid  = 1'b0;

        case (state_q)
            IDLE: begin
                inReady = 1'b1;
                if (inValid) begin
                    work_d    = stateIn;
                    col_idx_d = 2'd0;
                    state_d   = bypass ? DONE : BUSY;
                end
            end

            BUSY: begin
                case (col_idx_q)
                    2'd0: work_d[127:96] = col_mixed;
                    2'd1: work_d[95:64]  = col_mixed;
                    2'd2: work_d[63:32]  = col_mixed;
                    2'd3: work_d[31:0]   = col_mixed;
                    default: work_d = work_q;
                endcase
                col_idx_d = col_idx_q + 2'd1;   // wraps to 0 after column 3
                if (col_idx_q == 2'd3) begin
                    state_d = DONE;
                end
            end

            DONE: begin
                outValid = 1'b1;
                if (outReady) begin
                    // Pop and (optionally) load on the same edge.
                    inReady = 1'b1;
                    if (inValid) begin
                        work_d    = stateIn;
                        col_idx_d = 2'd0;
                        state_d   = bypass ? DONE : BUSY;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d   = IDLE;
                col_idx_d = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            col_idx_q <= 2'd0;
            work_q    <= '0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            work_q    <= work_d;
        end
    end

    assign stateOut = work_q;

endmodule

// File: tb/tb_mix_columns_iter.sv
module tb_mix_columns_iter;

    logic         clk;
    logic         rst_n;
    logic         inValid;
    logic [127:0] stateIn;
    logic         bypass;
    logic         outReady;

    logic         fwd_in_ready, fwd_out_valid;
    logic [127:0] fwd_state_out;
    logic         inv_in_ready, inv_out_valid;
    logic [127:0] inv_state_out;

    int n_checks = 0;
    int n_pass   = 0;

    mix_columns_iter #(.INVERSE(1'b0)) dut_fwd (
        .clk      (clk),
        .rst_n    (rst_n),
        .inValid  (inValid),
        .inReady  (fwd_in_ready),
        .stateIn  (stateIn),
        .bypass   (bypass),
        .outValid (fwd_out_valid),
        .outReady (outReady),
        .stateOut (fwd_state_out)
    );

    mix_columns_iter #(.INVERSE(1'b1)) dut_inv (
        .clk      (clk),
        .rst_n    (rst_n),
        .inValid  (inValid),
        .inReady  (inv_in_ready),
        .stateIn  (stateIn),
        .bypass   (bypass),
        .outValid (inv_out_valid),
        .outReady (outReady),
        .stateOut (inv_state_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    localparam logic [127:0] V1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] V1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] V2_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] V2_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;
    localparam logic [127:0] BP_A   = 128'h01234567_89abcdef_fedcba98_76543210;
    localparam logic [127:0] BP_B   = 128'hdeadbeef_00112233_a5a5a5a5_5a5a5a5a;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Present one state for one cycle; afterwards scramble stateIn so that
    // any late sampling shows up as a wrong result.
    task automatic send(input logic [127:0] v, input logic byp);
        inValid = 1'b1;
        stateIn = v;
        bypass  = byp;
        @(negedge clk);
        inValid = 1'b0;
        stateIn = ~v;
        bypass  = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cyc);
        cyc = 0;
        while (!fwd_out_valid && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    int  cyc;
    bit  stable;
    logic [127:0] held;

    initial begin
        rst_n    = 1'b0;
        inValid  = 1'b0;
        stateIn  = '0;
        bypass   = 1'b0;
        outReady = 1'b1;

        // ---------------- reset state ----------------
        #12;
        chk("reset_inReady",  {127'd0, fwd_in_ready},  128'd1);
        chk("reset_outValid", {127'd0, fwd_out_valid}, 128'd0);
        chk("reset_stateOut", fwd_state_out, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // ---------------- vector 1, forward ----------------
        send(V1_IN, 1'b0);
        chk("v1_busy_inReady", {127'd0, fwd_in_ready}, 128'd0);
        wait_valid(20, cyc);
        chk("v1_latency", 128'(cyc), 128'd4);
        chk("v1_stateOut", fwd_state_out, V1_OUT);
        chk("v1_done_inReady", {127'd0, fwd_in_ready}, 128'd1);
        $display("txn v1 fwd in=%h out=%h lat=%0d", V1_IN, fwd_state_out, cyc);
        @(negedge clk);
        chk("v1_pulse_outValid", {127'd0, fwd_out_valid}, 128'd0);
        chk("v1_idle_inReady",   {127'd0, fwd_in_ready},  128'd1);

        // ---------------- vector 2, forward ----------------
        send(V2_IN, 1'b0);
        wait_valid(20, cyc);
        chk("v2_latency", 128'(cyc), 128'd4);
        chk("v2_stateOut", fwd_state_out, V2_OUT);
        $display("txn v2 fwd in=%h out=%h lat=%0d", V2_IN, fwd_state_out, cyc);
        @(negedge clk);

        // ---------------- inverse instance ----------------
        send(V1_OUT, 1'b0);
        wait_valid(20, cyc);
        chk("inv_latency", 128'(cyc), 128'd4);
        chk("inv_outValid", {127'd0, inv_out_valid}, 128'd1);
        chk("inv_stateOut", inv_state_out, V1_IN);
        $display("txn inv in=%h out=%h lat=%0d", V1_OUT, inv_state_out, cyc);
        @(negedge clk);

        // ---------------- bypass ----------------
        send(BP_A, 1'b1);
        chk("bp_outValid", {127'd0, fwd_out_valid}, 128'd1);
        chk("bp_stateOut_fwd", fwd_state_out, BP_A);
        chk("bp_stateOut_inv", inv_state_out, BP_A);
        $display("txn bypass in=%h out=%h", BP_A, fwd_state_out);
        // back-to-back bypass: pop and load on the same edge
        send(BP_B, 1'b1);
        chk("bp2_outValid", {127'd0, fwd_out_valid}, 128'd1);
        chk("bp2_stateOut", fwd_state_out, BP_B);
        $display("txn bypass in=%h out=%h", BP_B, fwd_state_out);
        @(negedge clk);
        chk("bp2_drain_outValid", {127'd0, fwd_out_valid}, 128'd0);

        // ---------------- backpressure ----------------
        outReady = 1'b0;
        send(V1_IN, 1'b0);
        wait_valid(20, cyc);
        chk("bpr_latency", 128'(cyc), 128'd4);
        held   = fwd_state_out;
        stable = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (fwd_out_valid !== 1'b1 || fwd_state_out !== held || fwd_in_ready !== 1'b0)
                stable = 1'b0;
        end
        chk("bpr_stable", {127'd0, stable}, 128'd1);
        chk("bpr_stateOut", fwd_state_out, V1_OUT);
        chk("bpr_inReady_low", {127'd0, fwd_in_ready}, 128'd0);
        outReady = 1'b1;
        #1;
        chk("bpr_inReady_comb", {127'd0, fwd_in_ready}, 128'd1);
        $display("txn backpressure held out=%h for 10 cycles", held);
        send(V2_IN, 1'b0);
        chk("bpr_pop_outValid", {127'd0, fwd_out_valid}, 128'd0);
        chk("bpr_pop_inReady",  {127'd0, fwd_in_ready},  128'd0);
        wait_valid(20, cyc);
        chk("bpr_next_latency", 128'(cyc), 128'd4);
        chk("bpr_next_stateOut", fwd_state_out, V2_OUT);
        $display("txn pop+load in=%h out=%h lat=%0d", V2_IN, fwd_state_out, cyc);
        @(negedge clk);

        // ---------------- async reset mid-BUSY ----------------
        send(V1_IN, 1'b0);       // colIdx = 0
        @(negedge clk);          // column 0 mixed, colIdx = 1
        @(negedge clk);          // column 1 mixed, colIdx = 2
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_outValid", {127'd0, fwd_out_valid}, 128'd0);
        chk("arst_stateOut", fwd_state_out, 128'd0);
        chk("arst_inReady",  {127'd0, fwd_in_ready},  128'd1);
        $display("txn async reset during BUSY");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send(V2_IN, 1'b0);
        wait_valid(20, cyc);
        chk("arst_fresh_latency", 128'(cyc), 128'd4);
        chk("arst_fresh_stateOut", fwd_state_out, V2_OUT);
        $display("txn after reset in=%h out=%h lat=%0d", V2_IN, fwd_state_out, cyc);
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
